// File: rtl/sprite_commit_if.sv
// sprite_commit_if: word-copy write port from the commit scheduler to the active sprite registers.
interface sprite_commit_if #(parameter int IDX_W = 5);
    logic             copy_we;
    logic [IDX_W-1:0] copy_idx;
    logic             copy_ready;
    modport master (output copy_we, copy_idx, input copy_ready);
    modport slave (input copy_we, copy_idx, output copy_ready);
endinterface

// File: rtl/sprite_commit_sched.sv
// sprite_commit_sched: vsync-synchronous shadow-to-active sprite register commit sequencer.
// Optional COMMIT_WATCHDOG_EN aborts a copy stalled by copy_ready for WDOG_CYCLES cycles.
module sprite_commit_sched #(
    parameter int NUM_WORDS = 20,
    parameter int IDX_W = 5,
    parameter int FRAME_W = 16
`ifdef COMMIT_WATCHDOG_EN
    , parameter int WDOG_CYCLES = 64
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               stream_en,
    input  logic               commit_req,
    input  logic               auto_mode,
    input  logic [3:0]         frame_div,
    input  logic               irq_clr,
    sprite_commit_if.master    cp,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               irq,
    output logic               overrun,
    output logic               err
);
    typedef enum logic [1:0] {IDLE, ARMED, COPY, DONE} state_t;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WORDS - 1);
    state_t     state;
    logic       vsync_q, pend_nxt, vs_rise, areq, req, hs, wd_trip;
    logic [3:0] div;
    assign vs_rise = vsync & ~vsync_q & stream_en;
    assign areq = auto_mode & vs_rise & (div == frame_div);
    assign req = commit_req | areq;
    assign hs = cp.copy_we & cp.copy_ready;
`ifdef COMMIT_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_CYCLES + 1);
    logic [WD_W-1:0] wd;
    assign wd_trip = cp.copy_we & ~cp.copy_ready & (wd == WD_W'(WDOG_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wd <= '0;
            err <= 1'b0;
        end else begin
            wd <= (cp.copy_we && !cp.copy_ready && !wd_trip) ? wd + 1'b1 : '0;
            err <= wd_trip | (err & ~irq_clr);
        end
`else
    assign wd_trip = 1'b0;
    assign err = 1'b0;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            vsync_q <= 1'b0;
            div <= '0;
            pend_nxt <= 1'b0;
            cp.copy_we <= 1'b0;
            cp.copy_idx <= '0;
            busy <= 1'b0;
            frame_cnt <= '0;
            irq <= 1'b0;
            overrun <= 1'b0;
        end else begin
            vsync_q <= vsync;
            frame_cnt <= frame_cnt + FRAME_W'(vs_rise);
            div <= (!auto_mode || areq) ? '0 : div + 4'(vs_rise);
            if (irq_clr) begin
                irq <= 1'b0;
                overrun <= 1'b0;
            end
            case (state)
                IDLE: if (req) begin
                    state <= ARMED;
                    busy <= 1'b1;
                end
                // without display timing there is no vsync to wait for
                ARMED: if (vs_rise || !stream_en) begin
                    state <= COPY;
                    cp.copy_we <= 1'b1;
                    cp.copy_idx <= '0;
                end
                COPY: begin
                    if (vs_rise) overrun <= 1'b1;
                    if (req) pend_nxt <= 1'b1;
                    if (wd_trip) begin
                        state <= IDLE;
                        cp.copy_we <= 1'b0;
                        busy <= 1'b0;
                        pend_nxt <= 1'b0;
                    end else if (hs && cp.copy_idx == LAST) begin
                        state <= DONE;
                        cp.copy_we <= 1'b0;
                    end else if (hs) cp.copy_idx <= cp.copy_idx + 1'b1;
                end
                DONE: begin
                    irq <= 1'b1;
                    pend_nxt <= 1'b0;
                    state <= (pend_nxt || req) ? ARMED : IDLE;
                    busy <= pend_nxt | req;
                end
            endcase
        end
endmodule
